// File: rtl/byte_serializer_if.sv
// Upstream byte handshake: producer offers data/valid, serializer answers with ready.
interface byte_serializer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/byte_serializer.sv
// Byte-to-serial framer: start bit, 8 data bits, optional even parity, stop bit.
// Every line bit is held CLKS_PER_BIT cycles; all outputs come straight from flops.
module byte_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic               clk,
  input  logic               rst,
  byte_serializer_if.slave   up,
  output logic               sout,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 3;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shreg;
  logic             par;

  logic             next_bit_c;
  logic [7:0]       shifted_c;
  logic             bit_end_c;

  // Next data bit to put on the line and the register after it leaves
  always_comb begin
    next_bit_c = shreg[0];
    shifted_c  = {1'b0, shreg[7:1]};
    if (MSB_FIRST != 0) begin
      next_bit_c = shreg[7];
      shifted_c  = {shreg[6:0], 1'b0};
    end
    bit_end_c = (cnt == '0);
  end

  // Framing FSM with registered line and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sout     <= 1'b1;
      up.ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sout <= 1'b1;
          if (up.valid && up.ready) begin
            shreg    <= up.data;
            par      <= ^up.data;
            state    <= START;
            sout     <= 1'b0;
            up.ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= RELOAD;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (bit_end_c) begin
            state <= DATA;
            sout  <= next_bit_c;
            shreg <= shifted_c;
            cnt   <= RELOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end_c) begin
            cnt <= RELOAD;
            if (bit_cnt == BIT_W'(7)) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                sout  <= par;
              end else begin
                state <= STOP;
                sout  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              sout    <= next_bit_c;
              shreg   <= shifted_c;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        PARITY: begin
          if (bit_end_c) begin
            state <= STOP;
            sout  <= 1'b1;
            cnt   <= RELOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end_c) begin
            state    <= IDLE;
            sout     <= 1'b1;
            up.ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          sout     <= 1'b1;
          up.ready <= 1'b1;
          busy     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: default instance (a) and CLKS_PER_BIT=1/LSB-first/no-parity instance (b).
module tb_byte_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  byte_serializer_if ifa();
  byte_serializer_if ifb();
  logic sout_a, busy_a, done_a;
  logic sout_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  byte_serializer u_a (
    .clk  (clk),
    .rst  (rst),
    .up   (ifa),
    .sout (sout_a),
    .busy (busy_a),
    .done (done_a)
  );

  byte_serializer #(
    .CLKS_PER_BIT (1),
    .PARITY_EN    (0),
    .MSB_FIRST    (0)
  ) u_b (
    .clk  (clk),
    .rst  (rst),
    .up   (ifb),
    .sout (sout_b),
    .busy (busy_b),
    .done (done_b)
  );

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      ifb.valid = v;
      ifb.data  = d;
    end else begin
      ifa.valid = v;
      ifa.data  = d;
    end
  endtask

  task automatic get_out(input bit sel, output logic s, output logic bz,
                         output logic dn, output logic rd);
    if (sel) begin
      s = sout_b; bz = busy_b; dn = done_b; rd = ifb.ready;
    end else begin
      s = sout_a; bz = busy_a; dn = done_a; rd = ifa.ready;
    end
  endtask

  // Expected line waveform for one frame, one entry per clock cycle
  task automatic push_frame(input bit sel, input logic [7:0] b);
    int cpb;
    logic line[$];
    cpb = sel ? 1 : 4;
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(sel ? b[i] : b[7-i]);
    if (!sel) line.push_back(^b);
    line.push_back(1'b1);
    foreach (line[j]) repeat (cpb) exp_q.push_back(line[j]);
  endtask

  task automatic do_frame(input bit sel, input logic [7:0] b, input bit keep_valid,
                          input string tag);
    logic s, bz, dn, rd;
    int len;
    get_out(sel, s, bz, dn, rd);
    check({tag, "_ready_pre"}, rd, 1'b1);
    push_frame(sel, b);
    len = exp_q.size();
    drive(sel, 1'b1, b);
    step;
    drive(sel, keep_valid, keep_valid ? 8'($urandom) : 8'h00);
    for (int k = 0; k < len; k++) begin
      get_out(sel, s, bz, dn, rd);
      check({tag, "_sout"}, s, exp_q.pop_front());
      check({tag, "_busy"}, bz, 1'b1);
      check({tag, "_ready"}, rd, 1'b0);
      check({tag, "_done_early"}, dn, 1'b0);
      if (keep_valid) drive(sel, 1'b1, 8'($urandom));
      step;
    end
    get_out(sel, s, bz, dn, rd);
    check({tag, "_done"}, dn, 1'b1);
    check({tag, "_ready_done"}, rd, 1'b1);
    check({tag, "_busy_done"}, bz, 1'b0);
    check({tag, "_sout_done"}, s, 1'b1);
  endtask

  initial begin
    logic [7:0] rb;
    int seen;

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    step;
    step;
    check("rst_sout_a", sout_a, 1'b1);
    check("rst_ready_a", ifa.ready, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_sout_b", sout_b, 1'b1);
    check("rst_ready_b", ifb.ready, 1'b1);
    rst = 1'b0;
    step;

    do_frame(1'b0, 8'hA5, 1'b0, "a5");
    step;
    do_frame(1'b1, 8'h01, 1'b0, "b01");
    step;
    do_frame(1'b1, 8'h96, 1'b0, "b96");
    step;
    do_frame(1'b0, 8'h07, 1'b0, "par07");
    do_frame(1'b0, 8'h00, 1'b0, "par00");
    step;

    // valid held high with churning data: second handshake lands in the done cycle
    do_frame(1'b0, 8'hC3, 1'b1, "hold1");
    do_frame(1'b0, 8'h3C, 1'b0, "hold2");
    step;

    // mid-frame reset during the third data bit, preceded by an edge-free rst pulse
    rb = 8'hB2;
    drive(1'b0, 1'b1, rb);
    step;
    drive(1'b0, 1'b0, 8'h00);
    repeat (9) step;
    check("mid_bit1", sout_a, rb[6]);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (4) step;
    check("glitch_sout", sout_a, rb[5]);
    check("glitch_busy", busy_a, 1'b1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort_sout", sout_a, 1'b1);
    check("abort_ready", ifa.ready, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    seen = 0;
    repeat (50) begin
      step;
      if (done_a !== 1'b0 || sout_a !== 1'b1) seen++;
    end
    check("abort_quiet", seen == 0, 1'b1);
    do_frame(1'b0, 8'h5A, 1'b0, "post_rst");
    step;

    // reset wins over a simultaneous handshake
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'hFF);
    step;
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    check("coll_sout", sout_a, 1'b1);
    check("coll_ready", ifa.ready, 1'b1);
    check("coll_busy", busy_a, 1'b0);
    seen = 0;
    repeat (10) begin
      step;
      if (sout_a !== 1'b1 || busy_a !== 1'b0) seen++;
    end
    check("coll_quiet", seen == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held; legal range 1..255.
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 inserts an even-parity bit after the data bits, 0 omits it.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 sends data[7] first, 0 sends data[0] first.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port data, input, 8, parallel byte from the upstream rotate register output.
REQ-007 SHALL have port valid, input, 1, upstream byte offered.
REQ-008 SHALL have port ready, output, 1, block can accept a byte this cycle.
REQ-009 SHALL have port sout, output, 1, framed serial line, idle high.
REQ-010 SHALL have port busy, output, 1, frame in progress.
REQ-011 SHALL have port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL drive ready high only in IDLE, as a registered output.
REQ-014 SHALL drive busy as the complement of ready.
REQ-015 SHALL define a handshake as valid and ready both high at a rising edge.
REQ-016 On a handshake, SHALL capture data into an internal shift register and compute its even parity (XOR of the 8 bits).
REQ-017 On a handshake, SHALL enter START, with sout low from the next cycle.
REQ-018 SHALL ignore valid and data while busy; there is no queuing, and a later input change SHALL NOT alter the frame in flight.
REQ-019 SHALL hold each line bit (start, each data bit, parity, stop) on sout for exactly CLKS_PER_BIT cycles, timed by a cycle counter that reloads at every bit boundary.
REQ-020 START SHALL drive sout=0, then go to DATA.
REQ-021 DATA SHALL send 8 bits in the order set by MSB_FIRST, tracked by a 3-bit counter.
REQ-022 After the 8th data bit, DATA SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-023 PARITY SHALL drive sout = even-parity bit, then go to STOP.
REQ-024 STOP SHALL drive sout=1, then go to IDLE.
REQ-025 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles, counted from the first start-bit cycle to the last stop-bit cycle.
REQ-026 done SHALL be high for exactly the first cycle after the last stop-bit cycle; that cycle is also the first IDLE cycle (ready=1).
REQ-027 Minimum handshake spacing SHALL be frame length + 1 cycles; back-to-back frames SHALL be separated by sout=1 for at least 1 cycle beyond the stop bit.
REQ-028 CLKS_PER_BIT=1 SHALL work: each bit is held for one cycle, with no zero-length or skipped bits.
REQ-029 In IDLE, sout SHALL be 1.
REQ-030 sout, ready, busy and done SHALL all be driven directly from flops (glitch-free).

Reset
REQ-031 On a rising edge with rst=1, SHALL set state=IDLE, sout=1, ready=1, busy=0, done=0, and clear the counters and shift register.
REQ-032 rst SHALL take priority over a simultaneous handshake; the byte is not accepted.
REQ-033 Reset mid-frame SHALL abort the frame immediately (sout=1 after the reset edge) with no done pulse.
REQ-034 rst is synchronous; assertion without a clock edge SHALL have no effect.

Verification
REQ-035 Defaults, send 8'hA5 -> sout shows 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles); done=1 in cycle 45, with ready=1 in the same cycle.
REQ-036 MSB_FIRST=0, PARITY_EN=0, CLKS_PER_BIT=1, send 8'h01 -> sout shows 0,1,0,0,0,0,0,0,0,1 over 10 cycles; done in cycle 11.
REQ-037 Defaults, send 8'h07 -> parity bit = 1; then send 8'h00 -> parity bit = 0.
REQ-038 Hold valid=1 with changing data throughout a frame -> only the first byte is sent; the second handshake occurs in the done cycle and its start bit follows 1 cycle later.
REQ-039 Assert rst in the 3rd data bit -> sout=1, ready=1, busy=0 after the reset edge, done never pulses, and the next byte frames correctly.
REQ-040 Assert rst and a handshake on the same edge -> no frame starts and sout stays 1.
